// File: rtl/soc_event_pkg.sv
// Shared types and defaults for the SoC event dispatcher.
// Optional feature macro used by the top: SOC_EVT_DISP_MASK_EN.
package soc_event_pkg;

  localparam int unsigned SOC_EVT_NUM = 8;

  typedef logic [$clog2(SOC_EVT_NUM)-1:0] evt_id_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } disp_state_e;

endpackage

// File: rtl/soc_event_rr_arb.sv
// Combinational round-robin picker: one-hot grant and encoded index of the
// first eligible line at or after ptr, wrapping modulo NUM_EVT.
module soc_event_rr_arb #(
  parameter int unsigned NUM_EVT = 8,
  parameter int unsigned ID_W    = $clog2(NUM_EVT)
) (
  input  logic [NUM_EVT-1:0] elig,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_EVT-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [NUM_EVT-1:0] rot;
  int unsigned        pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = 0;
    // Rotating the doubled vector puts line ptr at bit 0, so a plain
    // lowest-set-bit scan yields round-robin order.
    rot = NUM_EVT'({elig, elig} >> ptr);
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      if (!any && rot[i]) begin
        any = 1'b1;
        pos = 32'(ptr) + i;
        if (pos >= NUM_EVT) pos = pos - NUM_EVT;
      end
    end
    idx = ID_W'(pos);
    if (any) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/soc_event_dispatcher.sv
// Round-robin dispatcher from per-line event queues to a registered
// valid/ready event output, plus overflow error aggregation.
// Optional line masking when SOC_EVT_DISP_MASK_EN is defined.
module soc_event_dispatcher
  import soc_event_pkg::*;
#(
  parameter int unsigned NUM_EVT = SOC_EVT_NUM,
  parameter int unsigned ID_W    = $clog2(NUM_EVT)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_EVT-1:0] evt_req_i,
  output logic [NUM_EVT-1:0] evt_ack_o,
  input  logic [NUM_EVT-1:0] q_err_i,
`ifdef SOC_EVT_DISP_MASK_EN
  input  logic [NUM_EVT-1:0] evt_mask_i,
`endif
  output logic               evt_valid_o,
  output logic [ID_W-1:0]    evt_id_o,
  input  logic               evt_ready_i,
  output logic               err_o,
  output logic               err_sticky_o,
  input  logic               err_clr_i
);

  disp_state_e        state;
  logic [ID_W-1:0]    ptr;
  logic [NUM_EVT-1:0] elig;
  logic [NUM_EVT-1:0] grant;
  logic [ID_W-1:0]    winner;
  logic               any;
  logic               load;
  logic [ID_W-1:0]    ptr_next;

`ifdef SOC_EVT_DISP_MASK_EN
  assign elig = evt_req_i & ~evt_mask_i;
`else
  assign elig = evt_req_i;
`endif

  soc_event_rr_arb #(
    .NUM_EVT (NUM_EVT),
    .ID_W    (ID_W)
  ) u_arb (
    .elig  (elig),
    .ptr   (ptr),
    .grant (grant),
    .idx   (winner),
    .any   (any)
  );

  // A pop is only issued when the output register can take the event.
  always_comb begin
    load      = any && ((state == EMPTY) || evt_ready_i);
    evt_ack_o = (load && !rst_i) ? grant : '0;
    ptr_next  = (winner == ID_W'(NUM_EVT - 1)) ? '0 : winner + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= EMPTY;
      ptr         <= '0;
      evt_valid_o <= 1'b0;
      evt_id_o    <= '0;
    end else begin
      if (load) begin
        state       <= FULL;
        evt_valid_o <= 1'b1;
        evt_id_o    <= winner;
        ptr         <= ptr_next;
      end else if (state == FULL && evt_ready_i) begin
        state       <= EMPTY;
        evt_valid_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_o        <= 1'b0;
      err_sticky_o <= 1'b0;
    end else begin
      err_o        <= |q_err_i;
      err_sticky_o <= (|q_err_i) | (err_sticky_o & ~err_clr_i);
    end
  end

endmodule

// File: tb/tb_soc_event_dispatcher.sv
// Scoreboard bench for soc_event_dispatcher: a reference model predicts acks
// and queues expected IDs, which are compared as the DUT presents them.
module tb_soc_event_dispatcher;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst_i;
  logic [N-1:0] evt_req_i;
  logic [N-1:0] evt_ack_o;
  logic [N-1:0] q_err_i;
  logic [N-1:0] mask;
  logic         evt_valid_o;
  logic [2:0]   evt_id_o;
  logic         evt_ready_i;
  logic         err_o;
  logic         err_sticky_o;
  logic         err_clr_i;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned exp_q[$];
  logic        m_full;
  int unsigned m_ptr;
  logic        m_err;
  logic        m_sticky;

  soc_event_dispatcher #(
    .NUM_EVT (N)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .evt_req_i    (evt_req_i),
    .evt_ack_o    (evt_ack_o),
    .q_err_i      (q_err_i),
`ifdef SOC_EVT_DISP_MASK_EN
    .evt_mask_i   (mask),
`endif
    .evt_valid_o  (evt_valid_o),
    .evt_id_o     (evt_id_o),
    .evt_ready_i  (evt_ready_i),
    .err_o        (err_o),
    .err_sticky_o (err_sticky_o),
    .err_clr_i    (err_clr_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned rr_pick(input logic [N-1:0] e, input int unsigned p);
    for (int unsigned k = 0; k < N; k++)
      if (e[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  // Reference model and scoreboard, evaluated mid-cycle on stable inputs.
  always @(negedge clk) begin
    logic [N-1:0] elig;
    logic [N-1:0] exp_ack;
    logic         m_load;
    int unsigned  w;
    if (rst_i) begin
      m_full   = 1'b0;
      m_ptr    = 0;
      m_err    = 1'b0;
      m_sticky = 1'b0;
      exp_q.delete();
    end else begin
`ifdef SOC_EVT_DISP_MASK_EN
      elig = evt_req_i & ~mask;
`else
      elig = evt_req_i;
`endif
      check("valid", {31'b0, evt_valid_o}, {31'b0, m_full});
      if (m_full && exp_q.size() > 0) check("id", {29'b0, evt_id_o}, exp_q[0]);
      if (m_full && evt_ready_i) void'(exp_q.pop_front());
      m_load  = (|elig) && (!m_full || evt_ready_i);
      exp_ack = '0;
      w       = rr_pick(elig, m_ptr);
      if (m_load) exp_ack[w] = 1'b1;
      check("ack", {24'b0, evt_ack_o}, {24'b0, exp_ack});
      if (m_load) begin
        exp_q.push_back(w);
        m_ptr  = (w + 1) % N;
        m_full = 1'b1;
      end else if (m_full && evt_ready_i) begin
        m_full = 1'b0;
      end
      check("err", {31'b0, err_o}, {31'b0, m_err});
      check("sticky", {31'b0, err_sticky_o}, {31'b0, m_sticky});
      m_err    = |q_err_i;
      m_sticky = (|q_err_i) | (m_sticky & ~err_clr_i);
    end
  end

  task automatic cyc(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_i       = 1'b1;
    evt_req_i   = '0;
    q_err_i     = '0;
    mask        = '0;
    evt_ready_i = 1'b0;
    err_clr_i   = 1'b0;
    cyc(2);
    check("rst_valid", {31'b0, evt_valid_o}, 32'd0);
    check("rst_ack", {24'b0, evt_ack_o}, 32'd0);
    rst_i = 1'b0;

    // All lines pending: ids rotate 0..7 then wrap.
    evt_req_i   = 8'hFF;
    evt_ready_i = 1'b1;
    cyc(12);

    // Async reset while FULL with a nonzero id held.
    #2 rst_i = 1'b1;
    #1;
    check("arst_valid", {31'b0, evt_valid_o}, 32'd0);
    check("arst_id", {29'b0, evt_id_o}, 32'd0);
    check("arst_ack", {24'b0, evt_ack_o}, 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;

    // Single requester, granted every cycle from ptr 0.
    evt_req_i = 8'h01;
    cyc(6);
    evt_req_i = '0;
    cyc(3);

    // Backpressure: one pop of line 2, held, then line 5.
    evt_ready_i = 1'b0;
    evt_req_i   = 8'h24;
    cyc(1);
    evt_req_i   = 8'h20;
    cyc(5);
    evt_ready_i = 1'b1;
    cyc(1);
    evt_req_i   = '0;
    cyc(3);

    // Error aggregation and sticky clear priority.
    q_err_i   = 8'h08;
    cyc(1);
    q_err_i   = '0;
    cyc(3);
    err_clr_i = 1'b1;
    cyc(1);
    err_clr_i = 1'b0;
    cyc(2);
    q_err_i   = 8'h08;
    cyc(1);
    q_err_i   = 8'h08;
    err_clr_i = 1'b1;
    cyc(1);
    q_err_i   = '0;
    cyc(1);
    err_clr_i = 1'b0;
    cyc(2);

`ifdef SOC_EVT_DISP_MASK_EN
    evt_req_i = 8'h03;
    mask      = 8'h01;
    cyc(4);
    mask      = '0;
    cyc(3);
    evt_req_i = '0;
    cyc(2);
`endif

    for (int i = 0; i < 300; i++) begin
      evt_req_i   = N'($urandom);
      evt_ready_i = ($urandom_range(0, 3) != 0);
      q_err_i     = ($urandom_range(0, 7) == 0) ? N'(1 << $urandom_range(0, N - 1)) : '0;
      err_clr_i   = ($urandom_range(0, 5) == 0);
`ifdef SOC_EVT_DISP_MASK_EN
      mask        = N'($urandom);
`endif
      cyc(1);
    end

    evt_req_i   = '0;
    q_err_i     = '0;
    err_clr_i   = 1'b0;
    evt_ready_i = 1'b1;
    cyc(3);
    check("drain", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
